// File: rtl/ign_pkg.sv
// Shared definitions for the ignition scheduler: channel states and default
// angle/latency constants.
package ign_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DWELL = 2'd2
   } chan_state_t;

   localparam int DEF_SHIFT  = 7;
   localparam int DEF_COMP   = 4;
   localparam int DEF_MARGIN = 20;

endpackage

// File: rtl/ign_chan.sv
// One ignition channel: arming window check, spark delay / dwell-start
// arithmetic, and the IDLE/WAIT/DWELL sequencer with its tick counter.
module ign_chan
   import ign_pkg::*;
#(
   parameter int PHASE_W  = 16,
   parameter int PERIOD_W = 32,
   parameter int SHIFT    = DEF_SHIFT,
   parameter int COMP     = DEF_COMP,
   parameter int MARGIN   = DEF_MARGIN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                trigger,
   input  logic [PHASE_W-1:0]  eng_phase,
   input  logic [PHASE_W-1:0]  next_tooth_width,
   input  logic [PERIOD_W-1:0] tooth_period,
   input  logic [PHASE_W-1:0]  timing,
   input  logic [PERIOD_W-1:0] dwell,
   input  logic                enable,
   output logic                coil,
   output logic                spark,
   output logic                busy,
   output logic                missed,
   output logic                short_dwell
);

   localparam int PW = PERIOD_W + PHASE_W;
   localparam logic [PW-1:0] D_MAX  = PW'({PERIOD_W{1'b1}});
   localparam logic [PW-1:0] COMP_W = PW'(COMP);

   chan_state_t         state;
   logic [PERIOD_W-1:0] cnt, d_q, s_q, d_new, s_new;
   logic [PHASE_W+1:0]  win_hi;
   logic [PHASE_W-1:0]  angle;
   logic [PW-1:0]       prod, shifted;
   logic                arm;

   // Window upper bound is widened so a large tooth width cannot wrap it.
   assign win_hi  = {2'b00, eng_phase} + {2'b00, next_tooth_width} + (PHASE_W+2)'(MARGIN);
   assign arm     = trigger && enable && (timing > eng_phase) && ({2'b00, timing} <= win_hi);
   assign angle   = timing - eng_phase;
   assign prod    = PW'(tooth_period) * PW'(angle);
   assign shifted = prod >> SHIFT;
   assign busy    = (state != S_IDLE);

   always_comb begin
      d_new = '0;
      if (shifted >= COMP_W) begin
         if (shifted - COMP_W > D_MAX) d_new = '1;
         else                          d_new = PERIOD_W'(shifted - COMP_W);
      end
      s_new = (dwell < d_new) ? d_new - dwell : '0;
   end

   // Direct entry to DWELL (no wait phase) leaves coil low for one edge so the
   // charge starts one cycle after arming, same as a zero-length wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         d_q         <= '0;
         s_q         <= '0;
         coil        <= 1'b0;
         spark       <= 1'b0;
         missed      <= 1'b0;
         short_dwell <= 1'b0;
      end else begin
         spark       <= 1'b0;
         missed      <= 1'b0;
         short_dwell <= 1'b0;
         case (state)
            S_IDLE: if (arm) begin
               cnt   <= '0;
               d_q   <= d_new;
               s_q   <= s_new;
               state <= (s_new == '0) ? S_DWELL : S_WAIT;
            end
            S_WAIT: begin
               missed <= arm;
               cnt    <= cnt + 1'b1;
               if (!enable) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else if (cnt >= s_q) begin
                  state <= S_DWELL;
                  coil  <= 1'b1;
               end
            end
            S_DWELL: begin
               missed <= arm;
               cnt    <= cnt + 1'b1;
               if (!coil) begin
                  coil        <= 1'b1;
                  short_dwell <= 1'b1;
               end else if (cnt >= d_q) begin
                  coil  <= 1'b0;
                  spark <= 1'b1;
                  state <= S_IDLE;
                  cnt   <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ign_sched.sv
// Multi-channel ignition scheduler: N_CH independent channels sharing the
// tooth event, engine phase and tooth period.
module ign_sched
   import ign_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int PHASE_W  = 16,
   parameter int PERIOD_W = 32,
   parameter int SHIFT    = DEF_SHIFT,
   parameter int COMP     = DEF_COMP,
   parameter int MARGIN   = DEF_MARGIN
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trigger,
   input  logic [PHASE_W-1:0]       eng_phase,
   input  logic [PHASE_W-1:0]       next_tooth_width,
   input  logic [PERIOD_W-1:0]      tooth_period,
   input  logic [N_CH*PHASE_W-1:0]  timing,
   input  logic [N_CH*PERIOD_W-1:0] dwell,
   input  logic [N_CH-1:0]          enable,
   output logic [N_CH-1:0]          coil,
   output logic [N_CH-1:0]          spark,
   output logic [N_CH-1:0]          busy,
   output logic [N_CH-1:0]          missed,
   output logic [N_CH-1:0]          short_dwell
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      ign_chan #(
         .PHASE_W (PHASE_W),
         .PERIOD_W(PERIOD_W),
         .SHIFT   (SHIFT),
         .COMP    (COMP),
         .MARGIN  (MARGIN)
      ) u_chan (
         .clk             (clk),
         .rst             (rst),
         .trigger         (trigger),
         .eng_phase       (eng_phase),
         .next_tooth_width(next_tooth_width),
         .tooth_period    (tooth_period),
         .timing          (timing[i*PHASE_W +: PHASE_W]),
         .dwell           (dwell[i*PERIOD_W +: PERIOD_W]),
         .enable          (enable[i]),
         .coil            (coil[i]),
         .spark           (spark[i]),
         .busy            (busy[i]),
         .missed          (missed[i]),
         .short_dwell     (short_dwell[i])
      );
   end

endmodule

// File: tb/tb_ign_sched.sv
// Bench for ign_sched: directed timing scenarios plus randomized traffic
// checked against an event-time model of each channel.
module tb_ign_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         trigger;
   logic [15:0]  eng_phase, next_tooth_width;
   logic [31:0]  tooth_period;
   logic [63:0]  timing;
   logic [127:0] dwell;
   logic [3:0]   enable;
   logic [3:0]   coil, spark, busy, missed, short_dwell;

   int n_cmp = 0;
   int n_bad = 0;

   // model: per channel, the edge it armed on and the edges at which the
   // coil must rise and the spark must fire
   longint cyc = 0;
   bit     m_armed [4];
   longint m_k [4], m_d [4], m_s [4], m_rise [4], m_spk [4];
   logic [3:0] exp_coil, exp_spark, exp_busy, exp_missed, exp_short;

   always #5 clk = ~clk;

   ign_sched dut (
      .clk(clk), .rst(rst), .trigger(trigger), .eng_phase(eng_phase),
      .next_tooth_width(next_tooth_width), .tooth_period(tooth_period),
      .timing(timing), .dwell(dwell), .enable(enable), .coil(coil),
      .spark(spark), .busy(busy), .missed(missed), .short_dwell(short_dwell)
   );

   function automatic longint calc_d(longint per, longint ang);
      longint sh;
      sh = (per * ang) >> 7;
      if (sh < 4) return 0;
      if (sh - 4 > 64'hFFFF_FFFF) return 64'hFFFF_FFFF;
      return sh - 4;
   endfunction

   task automatic model_clear();
      for (int ch = 0; ch < 4; ch++) m_armed[ch] = 0;
      exp_coil = '0; exp_spark = '0; exp_busy = '0; exp_missed = '0; exp_short = '0;
   endtask

   // Advance one clock: the model evaluates the inputs the DUT will sample,
   // then we return at the following falling edge.
   task automatic tick();
      longint e;
      e = cyc + 1;
      for (int ch = 0; ch < 4; ch++) begin
         longint t, p, w, dw, d, s;
         bit armc;
         t  = timing[ch*16 +: 16];
         p  = eng_phase;
         w  = next_tooth_width;
         dw = dwell[ch*32 +: 32];
         armc = trigger && enable[ch] && (t > p) && (t <= p + w + 20);
         exp_spark[ch] = 0; exp_missed[ch] = 0;
         if (m_armed[ch]) begin
            if (m_s[ch] > 0 && e <= m_rise[ch] && !enable[ch]) m_armed[ch] = 0;
            else begin
               if (armc) exp_missed[ch] = 1;
               if (e == m_spk[ch]) begin m_armed[ch] = 0; exp_spark[ch] = 1; end
            end
         end else if (armc) begin
            d = calc_d(tooth_period, t - p);
            s = (dw < d) ? d - dw : 0;
            m_armed[ch] = 1; m_k[ch] = e; m_d[ch] = d; m_s[ch] = s;
            m_rise[ch] = e + 1 + s;
            m_spk[ch]  = (e + 1 + d > m_rise[ch]) ? e + 1 + d : m_rise[ch] + 1;
         end
         exp_busy[ch]  = m_armed[ch];
         exp_coil[ch]  = m_armed[ch] && e >= m_rise[ch] && e < m_spk[ch];
         exp_short[ch] = m_armed[ch] && e == m_k[ch] + 1 && m_s[ch] == 0;
      end
      cyc = e;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      trigger = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_ch0(input logic [15:0] t, input logic [31:0] d);
      timing[15:0] = t;
      dwell[31:0]  = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({coil, spark, busy, missed, short_dwell} !== 20'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h expected 00000", {coil, spark, busy, missed, short_dwell});
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      longint k, rise = -1, spk = -1;
      int nspk = 0, ovl = 0;
      eng_phase = 100; next_tooth_width = 30; tooth_period = 1280;
      enable = 4'b0001; set_ch0(110, 40);
      trigger = 1; tick(); trigger = 0; k = cyc;
      n_cmp++;
      if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b expected 1", busy[0]); end
      for (int i = 1; i <= 110; i++) begin
         tick();
         if (coil[0] && rise < 0) rise = cyc - k;
         if (spark[0]) begin nspk++; spk = cyc - k; end
         if (coil[0] && spark[0]) ovl++;
      end
      n_cmp++; if (rise != 57) begin n_bad++; $display("FAIL basic_coil_rise: got %0d expected 57", rise); end
      n_cmp++; if (spk != 97)  begin n_bad++; $display("FAIL basic_spark: got %0d expected 97", spk); end
      n_cmp++; if (nspk != 1 || ovl != 0) begin n_bad++; $display("FAIL basic_spark_once: got %0d/%0d expected 1/0", nspk, ovl); end
      n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got %b expected 0", busy[0]); end
   endtask

   task automatic test_short_dwell();
      longint k, rise = -1, spk = -1, sh = -1;
      int nsh = 0;
      set_ch0(110, 200);
      trigger = 1; tick(); trigger = 0; k = cyc;
      for (int i = 1; i <= 110; i++) begin
         tick();
         if (coil[0] && rise < 0) rise = cyc - k;
         if (spark[0]) spk = cyc - k;
         if (short_dwell[0]) begin nsh++; sh = cyc - k; end
      end
      n_cmp++; if (sh != 1 || nsh != 1) begin n_bad++; $display("FAIL short_pulse: got %0d x%0d expected 1 x1", sh, nsh); end
      n_cmp++; if (rise != 1) begin n_bad++; $display("FAIL short_coil_rise: got %0d expected 1", rise); end
      n_cmp++; if (spk != 97) begin n_bad++; $display("FAIL short_spark: got %0d expected 97", spk); end
   endtask

   task automatic test_window();
      logic [15:0] tv [3] = '{16'd100, 16'd151, 16'd150};
      logic        ev [3] = '{1'b0, 1'b0, 1'b1};
      for (int j = 0; j < 3; j++) begin
         do_reset();
         set_ch0(tv[j], 40);
         trigger = 1; tick(); trigger = 0; tick();
         n_cmp++;
         if (busy[0] !== ev[j]) begin
            n_bad++; $display("FAIL window_t%0d: got busy %b expected %b", tv[j], busy[0], ev[j]);
         end
      end
      do_reset();
   endtask

   task automatic test_missed();
      longint k, spk = -1, mc = -1;
      int nm = 0;
      set_ch0(110, 40);
      trigger = 1; tick(); trigger = 0; k = cyc;
      for (int i = 1; i <= 110; i++) begin
         trigger = (i == 30);
         tick();
         if (missed[0]) begin nm++; mc = cyc - k; end
         if (spark[0]) spk = cyc - k;
      end
      trigger = 0;
      n_cmp++; if (mc != 30 || nm != 1) begin n_bad++; $display("FAIL missed_pulse: got %0d x%0d expected 30 x1", mc, nm); end
      n_cmp++; if (spk != 97) begin n_bad++; $display("FAIL missed_spark: got %0d expected 97", spk); end
   endtask

   task automatic test_parallel_reset();
      longint k;
      longint sp [4] = '{-1, -1, -1, -1};
      int nspk = 0;
      timing = {16'd107, 16'd105, 16'd103, 16'd110};
      dwell  = {32'd30, 32'd20, 32'd10, 32'd40};
      enable = 4'hF;
      trigger = 1; tick(); trigger = 0; k = cyc;
      for (int i = 1; i <= 69; i++) begin
         tick();
         n_cmp++;
         if ({coil, spark, busy, missed, short_dwell} !== {exp_coil, exp_spark, exp_busy, exp_missed, exp_short}) begin
            n_bad++;
            $display("FAIL parallel_c%0d: got %h expected %h", i, {coil, spark, busy, missed, short_dwell},
                     {exp_coil, exp_spark, exp_busy, exp_missed, exp_short});
         end
         for (int ch = 0; ch < 4; ch++) if (spark[ch]) sp[ch] = cyc - k;
      end
      n_cmp++;
      if (sp[1] != 27 || sp[2] != 47 || sp[3] != 67) begin
         n_bad++; $display("FAIL parallel_sparks: got %0d %0d %0d expected 27 47 67", sp[1], sp[2], sp[3]);
      end
      n_cmp++; if (coil[0] !== 1'b1) begin n_bad++; $display("FAIL pre_reset_coil: got %b expected 1", coil[0]); end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (coil !== 4'h0 || busy !== 4'h0) begin
         n_bad++; $display("FAIL async_reset: got coil %b busy %b expected 0000 0000", coil, busy);
      end
      model_clear();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (spark[0] || busy[0]) nspk++;
      end
      n_cmp++; if (nspk != 0) begin n_bad++; $display("FAIL post_reset_quiet: got %0d expected 0", nspk); end
   endtask

   task automatic test_saturation();
      longint k, rise = -1, spk = -1;
      int ovl = 0, nsh = 0;
      do_reset();
      enable = 4'b0001; eng_phase = 100; next_tooth_width = 30; tooth_period = 1;
      set_ch0(101, 5);
      trigger = 1; tick(); trigger = 0; k = cyc;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (coil[0] && rise < 0) rise = cyc - k;
         if (spark[0]) spk = cyc - k;
         if (coil[0] && spark[0]) ovl++;
      end
      n_cmp++;
      if (rise != 1 || spk != 2 || ovl != 0) begin
         n_bad++; $display("FAIL d_floor: got rise %0d spark %0d ovl %0d expected 1 2 0", rise, spk, ovl);
      end
      do_reset();
      eng_phase = 0; next_tooth_width = 16'hFFFF; tooth_period = 32'hFFFF_FFFF;
      set_ch0(16'hFFFF, 32'hFFFF_FFFE);
      rise = -1;
      trigger = 1; tick(); trigger = 0; k = cyc;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (coil[0] && rise < 0) rise = cyc - k;
         if (short_dwell[0]) nsh++;
      end
      n_cmp++;
      if (rise != 2 || nsh != 0 || busy[0] !== 1'b1) begin
         n_bad++; $display("FAIL d_saturate: got rise %0d short %0d busy %b expected 2 0 1", rise, nsh, busy[0]);
      end
      do_reset();
   endtask

   task automatic test_random();
      do_reset();
      enable = 4'hF;
      for (int i = 0; i < 2500; i++) begin
         eng_phase        = 16'($urandom_range(0, 2000));
         next_tooth_width = 16'($urandom_range(10, 60));
         tooth_period     = $urandom_range(64, 400);
         for (int ch = 0; ch < 4; ch++) begin
            timing[ch*16 +: 16] = eng_phase + 16'($urandom_range(0, next_tooth_width + 24));
            dwell[ch*32 +: 32]  = $urandom_range(1, 120);
            if ($urandom_range(0, 39) == 0) enable[ch] = ~enable[ch];
         end
         trigger = ($urandom_range(0, 5) == 0);
         tick();
         n_cmp++;
         if ({coil, spark, busy, missed, short_dwell} !== {exp_coil, exp_spark, exp_busy, exp_missed, exp_short}) begin
            n_bad++;
            $display("FAIL random_c%0d: got %h expected %h", i, {coil, spark, busy, missed, short_dwell},
                     {exp_coil, exp_spark, exp_busy, exp_missed, exp_short});
         end
      end
      trigger = 0;
   endtask

   initial begin
      rst = 1'b1; trigger = 0; eng_phase = 0; next_tooth_width = 0;
      tooth_period = 0; timing = '0; dwell = '0; enable = '0;
      model_clear();
      @(negedge clk);
      test_reset();
      test_basic();
      test_short_dwell();
      test_window();
      test_missed();
      test_parallel_reset();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
